// File: rtl/conv_mac_engine_if.sv
// Window-in / result-out stream bundle for conv_mac_engine.
// master = window producer and result consumer; slave = the engine.
interface conv_mac_engine_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ACC_WIDTH    = 32,
    parameter int NUM_CHANNELS = 4,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
);
    logic                    win_valid;
    logic                    win_ready;
    logic [9*DATA_WIDTH-1:0] win_data;
    logic                    win_pad;
    logic                    res_valid;
    logic                    res_ready;
    logic [ACC_WIDTH-1:0]    res_data;
    logic [CH_W-1:0]         res_chan;
    logic                    res_last;

    modport master (
        output win_valid, win_data, win_pad, res_ready,
        input  win_ready, res_valid, res_data, res_chan, res_last
    );

    modport slave (
        input  win_valid, win_data, win_pad, res_ready,
        output win_ready, res_valid, res_data, res_chan, res_last
    );
endinterface

// File: rtl/conv_mac_engine.sv
// Multi-channel MAC stage: one window of up to 9 unsigned pixels in, one signed
// result per output channel out (dot product + bias, optional ReLU), channel-serial.
module conv_mac_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int BIAS_WIDTH     = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int NUM_CHANNELS   = 4,
    parameter int MULT_PER_CYCLE = 3,
    parameter logic [ACC_WIDTH-1:0] PAD_VAL = '1,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cfg_window_3x3_i,
    input  logic                  cfg_relu_en_i,
    input  logic [15:0]           cfg_frame_windows_i,
    input  logic                  wt_wr_en_i,
    input  logic [CH_W-1:0]       wt_wr_chan_i,
    input  logic [3:0]            wt_wr_tap_i,
    input  logic [DATA_WIDTH-1:0] wt_wr_data_i,
    input  logic                  bias_wr_en_i,
    input  logic [CH_W-1:0]       bias_wr_chan_i,
    input  logic [BIAS_WIDTH-1:0] bias_wr_data_i,
    conv_mac_engine_if.slave      bus,
    output logic                  frame_done_o,
    output logic                  idle_o
);
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    localparam int STEPS_3X3 = (9 + MULT_PER_CYCLE - 1) / MULT_PER_CYCLE;
    localparam int STEP_W    = (STEPS_3X3 > 1) ? $clog2(STEPS_3X3) : 1;

    state_t state_q, state_d;

    logic        [DATA_WIDTH-1:0] taps_q    [9];
    logic signed [DATA_WIDTH-1:0] weights_q [NUM_CHANNELS][9];
    logic signed [BIAS_WIDTH-1:0] bias_q    [NUM_CHANNELS];
    acc_t                         results_q [NUM_CHANNELS];
    acc_t                         acc_q;
    logic                         win_3x3_q;
    logic                         relu_q;
    logic [CH_W-1:0]              mac_chan_q;
    logic [CH_W-1:0]              out_chan_q;
    logic [STEP_W-1:0]            step_q;
    logic [15:0]                  frame_cnt_q;
    logic                         frame_done_q;

    logic accept, res_fire, out_last, mac_chan_last, step_last;
    logic wt_wr_ok, bias_wr_ok;
    acc_t step_sum, acc_sum, acc_final;
    wire  [MULT_PER_CYCLE*ACC_WIDTH-1:0] prod_flat;

    assign accept        = (state_q == S_IDLE) && bus.win_valid;
    assign res_fire      = (state_q == S_OUT) && bus.res_ready;
    assign out_last      = (out_chan_q == CH_W'(NUM_CHANNELS - 1));
    assign mac_chan_last = (mac_chan_q == CH_W'(NUM_CHANNELS - 1));
    assign step_last     = win_3x3_q ? (step_q == STEP_W'(STEPS_3X3 - 1)) : 1'b1;

    // Tables are only writable between windows so an in-flight MAC sees stable coefficients.
    assign wt_wr_ok   = (state_q == S_IDLE) && wt_wr_en_i && (wt_wr_tap_i <= 4'd8) &&
                        ({1'b0, wt_wr_chan_i} < (CH_W + 1)'(NUM_CHANNELS));
    assign bias_wr_ok = (state_q == S_IDLE) && bias_wr_en_i &&
                        ({1'b0, bias_wr_chan_i} < (CH_W + 1)'(NUM_CHANNELS));

    // Each lane handles tap step*M+gi; taps beyond the window size contribute nothing.
    for (genvar gi = 0; gi < MULT_PER_CYCLE; gi++) begin : g_mult
        int                           tap_idx;
        logic [3:0]                   tap_sel;
        logic signed [DATA_WIDTH:0]   pix_s;
        logic signed [2*DATA_WIDTH:0] prod;
        acc_t                         prod_ext;

        always_comb begin
            tap_idx  = int'(step_q) * MULT_PER_CYCLE + gi;
            tap_sel  = 4'(tap_idx);
            pix_s    = '0;
            prod     = '0;
            prod_ext = '0;
            if (tap_idx < (win_3x3_q ? 9 : 1)) begin
                pix_s    = {1'b0, taps_q[tap_sel]};
                prod     = pix_s * weights_q[mac_chan_q][tap_sel];
                prod_ext = acc_t'(prod);
            end
        end

        assign prod_flat[gi*ACC_WIDTH +: ACC_WIDTH] = prod_ext;
    end

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < MULT_PER_CYCLE; i++) begin
            step_sum = step_sum + acc_t'(prod_flat[i*ACC_WIDTH +: ACC_WIDTH]);
        end
        // Bias seeds the accumulator on the first step of each channel.
        acc_sum   = ((step_q == '0) ? acc_t'(bias_q[mac_chan_q]) : acc_q) + step_sum;
        acc_final = (relu_q && acc_sum[ACC_WIDTH-1]) ? '0 : acc_sum;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.win_valid) state_d = bus.win_pad ? S_OUT : S_MAC;
            S_MAC:   if (step_last && mac_chan_last) state_d = S_OUT;
            S_OUT:   if (bus.res_ready && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int t = 0; t < 9; t++) weights_q[c][t] <= '0;
                bias_q[c]    <= '0;
                results_q[c] <= '0;
            end
            for (int t = 0; t < 9; t++) taps_q[t] <= '0;
            acc_q        <= '0;
            win_3x3_q    <= 1'b0;
            relu_q       <= 1'b0;
            mac_chan_q   <= '0;
            out_chan_q   <= '0;
            step_q       <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (wt_wr_ok)   weights_q[wt_wr_chan_i][wt_wr_tap_i] <= wt_wr_data_i;
            if (bias_wr_ok) bias_q[bias_wr_chan_i] <= bias_wr_data_i;

            if (accept) begin
                for (int t = 0; t < 9; t++) taps_q[t] <= bus.win_data[t*DATA_WIDTH +: DATA_WIDTH];
                win_3x3_q  <= cfg_window_3x3_i;
                relu_q     <= cfg_relu_en_i;
                mac_chan_q <= '0;
                step_q     <= '0;
                out_chan_q <= '0;
                if (bus.win_pad) begin
                    for (int c = 0; c < NUM_CHANNELS; c++) results_q[c] <= PAD_VAL;
                end
            end

            if (state_q == S_MAC) begin
                acc_q <= acc_sum;
                if (step_last) begin
                    results_q[mac_chan_q] <= acc_final;
                    step_q     <= '0;
                    mac_chan_q <= mac_chan_last ? '0 : mac_chan_q + CH_W'(1);
                end else begin
                    step_q <= step_q + STEP_W'(1);
                end
            end

            if (res_fire) begin
                out_chan_q <= out_last ? '0 : out_chan_q + CH_W'(1);
                if (out_last) begin
                    if ((cfg_frame_windows_i != 16'd0) &&
                        (frame_cnt_q + 16'd1 == cfg_frame_windows_i)) begin
                        frame_cnt_q  <= '0;
                        frame_done_q <= 1'b1;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.win_ready = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_OUT);
    assign bus.res_data  = results_q[out_chan_q];
    assign bus.res_chan  = out_chan_q;
    assign bus.res_last  = (state_q == S_OUT) && out_last;
    assign frame_done_o  = frame_done_q;
    assign idle_o        = (state_q == S_IDLE);
endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: hand-computed results, latency, backpressure,
// pad windows, write gating, frame pulse and mid-MAC reset.
module tb_conv_mac_engine;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_3x3 = 1'b1;
    logic          cfg_relu = 1'b0;
    logic [15:0]   cfg_frames = '0;
    logic          wt_en = 1'b0;
    logic [CW-1:0] wt_chan = '0;
    logic [3:0]    wt_tap = '0;
    logic [DW-1:0] wt_data = '0;
    logic          b_en = 1'b0;
    logic [CW-1:0] b_chan = '0;
    logic [15:0]   b_data = '0;
    logic          frame_done;
    logic          idle;
    int            checks = 0;
    int            failures = 0;
    int            lat;
    logic [71:0]   seq_win;
    logic [71:0]   one_win;

    always #5 clk = ~clk;

    conv_mac_engine_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_CHANNELS(NC)) bus ();

    conv_mac_engine #(
        .DATA_WIDTH(DW), .BIAS_WIDTH(16), .ACC_WIDTH(AW),
        .NUM_CHANNELS(NC), .MULT_PER_CYCLE(3)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_window_3x3_i(cfg_3x3), .cfg_relu_en_i(cfg_relu), .cfg_frame_windows_i(cfg_frames),
        .wt_wr_en_i(wt_en), .wt_wr_chan_i(wt_chan), .wt_wr_tap_i(wt_tap), .wt_wr_data_i(wt_data),
        .bias_wr_en_i(b_en), .bias_wr_chan_i(b_chan), .bias_wr_data_i(b_data),
        .bus(bus), .frame_done_o(frame_done), .idle_o(idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_wt(input int ch, input int tap, input int val);
        wt_en = 1'b1; wt_chan = CW'(ch); wt_tap = 4'(tap); wt_data = DW'(val);
        @(negedge clk);
        wt_en = 1'b0;
    endtask

    task automatic wr_bias(input int ch, input int val);
        b_en = 1'b1; b_chan = CW'(ch); b_data = 16'(val);
        @(negedge clk);
        b_en = 1'b0;
    endtask

    // Called at a negedge; returns 1ns after the accepting edge.
    task automatic send(input logic [71:0] data, input logic pad, input logic is3, input logic relu);
        chk("win_ready_before_send", bus.win_ready, 1'b1);
        bus.win_valid = 1'b1; bus.win_data = data; bus.win_pad = pad;
        cfg_3x3 = is3; cfg_relu = relu;
        @(posedge clk);
        #1 bus.win_valid = 1'b0; bus.win_pad = 1'b0;
        $display("window accepted pad=%0b 3x3=%0b relu=%0b data=%h", pad, is3, relu, data);
    endtask

    // Negedges counted from the accept edge until res_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.res_valid) break;
        end
    endtask

    task automatic collect(input int e0, input int e1, input int e2, input int e3);
        int exp_v [4];
        exp_v = '{e0, e1, e2, e3};
        for (int c = 0; c < NC; c++) begin
            chk("res_valid", bus.res_valid, 1'b1);
            chk("res_data", bus.res_data, exp_v[c]);
            chk("res_chan", 32'(bus.res_chan), c);
            chk("res_last", bus.res_last, c == NC - 1);
            $display("result chan=%0d data=%0d last=%0b", bus.res_chan, $signed(bus.res_data), bus.res_last);
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
        end
        chk("idle_after_out", idle, 1'b1);
    endtask

    initial begin
        bus.win_valid = 1'b0; bus.win_data = '0; bus.win_pad = 1'b0; bus.res_ready = 1'b0;
        for (int i = 0; i < 9; i++) seq_win[i*8 +: 8] = 8'(i + 1);
        one_win = {8{8'd255}};
        one_win = {one_win[71:8], 8'd200};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_win_ready", bus.win_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_chan", 32'(bus.res_chan), 32'd0);
        chk("rst_res_last", bus.res_last, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1) all weights 1, bias 0 -> 45 each, 13-cycle latency
        for (int c = 0; c < NC; c++) for (int t = 0; t < 9; t++) wr_wt(c, t, 1);
        send(seq_win, 1'b0, 1'b1, 1'b0);
        wait_valid(lat);
        chk("lat_3x3", lat, 13);
        collect(45, 45, 45, 45);

        // 2) ch1 weights -1, bias 10 -> -35; then with ReLU -> 0
        for (int t = 0; t < 9; t++) wr_wt(1, t, -1);
        wr_bias(1, 10);
        send(seq_win, 1'b0, 1'b1, 1'b0);
        wait_valid(lat);
        chk("lat_3x3_b", lat, 13);
        collect(45, -35, 45, 45);
        send(seq_win, 1'b0, 1'b1, 1'b1);
        wait_valid(lat);
        collect(45, 0, 45, 45);

        // 3) 1x1; ch2 weight/bias written together in the accept cycle
        wt_en = 1'b1; wt_chan = 2'd2; wt_tap = 4'd0; wt_data = 8'hFE;
        b_en = 1'b1; b_chan = 2'd2; b_data = 16'd5;
        send(one_win, 1'b0, 1'b0, 1'b0);
        wt_en = 1'b0; b_en = 1'b0;
        wait_valid(lat);
        chk("lat_1x1", lat, 5);
        collect(200, -190, -395, 200);

        // 4) backpressure: outputs hold for 5 cycles, then drain without loss
        send(seq_win, 1'b0, 1'b1, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_res_valid", bus.res_valid, 1'b1);
            chk("bp_res_data", bus.res_data, 32'd45);
            chk("bp_res_chan", 32'(bus.res_chan), 32'd0);
            chk("bp_win_ready", bus.win_ready, 1'b0);
            @(negedge clk);
        end
        collect(45, -35, 47, 45);

        // 5) pad window, ReLU on, streaming; weight write during OUT is ignored
        bus.res_ready = 1'b1;
        send(seq_win, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            wt_en = 1'b0;
            chk("pad_res_valid", bus.res_valid, 1'b1);
            chk("pad_res_data", bus.res_data, 32'hFFFF_FFFF);
            chk("pad_res_chan", 32'(bus.res_chan), c);
            $display("result chan=%0d data=0x%08h (pad)", bus.res_chan, bus.res_data);
            if (c == 1) begin
                wt_en = 1'b1; wt_chan = 2'd0; wt_tap = 4'd0; wt_data = 8'd7;
            end
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("pad_idle", idle, 1'b1);
        send(one_win, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        collect(200, -190, -395, 200);

        // 6) frame pulse after the third window
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cfg_frames = 16'd3;
        for (int w = 1; w <= 3; w++) begin
            send(seq_win, 1'b0, 1'b1, 1'b0);
            wait_valid(lat);
            collect(0, 0, 0, 0);
            chk("frame_done_pulse", frame_done, w == 3);
            @(negedge clk);
            chk("frame_done_after", frame_done, 1'b0);
        end

        // Reset mid-MAC aborts the window; next window sees zeroed weights
        for (int t = 0; t < 9; t++) wr_wt(0, t, 3);
        send(seq_win, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_res_valid", bus.res_valid, 1'b0);
        chk("mid_rst_idle", idle, 1'b1);
        repeat (15) @(negedge clk);
        chk("mid_rst_no_result", bus.res_valid, 1'b0);
        cfg_frames = 16'd0;
        wr_bias(0, 100);
        wr_bias(3, -7);
        send(seq_win, 1'b0, 1'b1, 1'b0);
        wait_valid(lat);
        chk("lat_after_rst", lat, 13);
        collect(100, 0, 0, -7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
